// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//   8N1 serial transmitter with a single-byte holding register so that a
//   second byte can be queued while a frame is on the line, giving
//   back-to-back frames with no idle gap.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     When defined, an even-parity bit (XOR of the 8 data bits) is inserted
//     between the last data bit and the stop bit (8E1, 11 bit periods).
//     When undefined, the frame is 8N1 (10 bit periods).
//
// Parameters
//   CLOCKS_PER_BIT : clk cycles per serial bit, legal range 2..65535
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   in_data_valid in   upstream offers a byte
//   in_data       in   byte to send, sampled only on accept
//   in_ready      out  holding slot free (accept = in_data_valid & in_ready)
//   out           out  serial line, registered, idle high
//   out_active    out  high whenever a frame is in progress
//   out_done      out  one-cycle pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_transmitter #(
    parameter int CLOCKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_data_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out,
    output logic       out_active,
    output logic       out_done
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);

    // Last count of a bit period, and the count just before it (used to
    // register out_done so it lines up with the final stop-bit cycle).
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLOCKS_PER_BIT - 2);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START_BIT  = 3'd1;
    localparam logic [2:0] DATA_BITS  = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY_BIT = 3'd3;
`endif
    localparam logic [2:0] STOP_BIT   = 3'd4;

`ifdef UART_TX_PARITY_EN
    // Even parity over a data byte.
    function automatic logic even_parity(input logic [7:0] b);
        even_parity = ^b;
    endfunction
`endif

    logic [2:0]    state_r,     state_s;
    logic [CW-1:0] cnt_r,       cnt_s;
    logic [2:0]    idx_r,       idx_s;
    logic [7:0]    shift_r,     shift_s;
    logic [7:0]    hold_r,      hold_s;
    logic          hold_full_r, hold_full_s;
    logic          out_r,       out_s;
    logic          done_r,      done_s;
    logic          active_r,    active_s;
    logic          ready_r,     ready_s;
`ifdef UART_TX_PARITY_EN
    logic          par_r,       par_s;
`endif
    logic          bit_end_s;
    logic          accept_s;

    // Next-state computation for the frame sequencer and holding register.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        shift_s     = shift_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        out_s       = out_r;
        done_s      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_s       = par_r;
`endif
        bit_end_s   = (cnt_r == CNT_LAST);
        accept_s    = in_data_valid & ready_r;

        if (bit_end_s) begin
            cnt_s = {CW{1'b0}};
        end else begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end

        case (state_r)
            IDLE: begin
                cnt_s       = {CW{1'b0}};
                idx_s       = 3'd0;
                hold_full_s = 1'b0;
                out_s       = 1'b1;
                if (accept_s) begin
                    shift_s = in_data;
`ifdef UART_TX_PARITY_EN
                    par_s   = even_parity(in_data);
`endif
                    state_s = START_BIT;
                    out_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            START_BIT: begin
                if (accept_s) begin
                    hold_s      = in_data;
                    hold_full_s = 1'b1;
                end else begin
                    hold_full_s = hold_full_r;
                end
                if (bit_end_s) begin
                    state_s = DATA_BITS;
                    idx_s   = 3'd0;
                    out_s   = shift_r[0];
                end else begin
                    out_s   = 1'b0;
                end
            end
            DATA_BITS: begin
                if (accept_s) begin
                    hold_s      = in_data;
                    hold_full_s = 1'b1;
                end else begin
                    hold_full_s = hold_full_r;
                end
                if (bit_end_s) begin
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY_BIT;
                        out_s   = par_r;
`else
                        state_s = STOP_BIT;
                        out_s   = 1'b1;
`endif
                    end else begin
                        // The shift register always presents the current bit
                        // in [0]; the next bit to drive sits in [1].
                        idx_s   = idx_r + 3'd1;
                        out_s   = shift_r[1];
                        shift_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    out_s = out_r;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (accept_s) begin
                    hold_s      = in_data;
                    hold_full_s = 1'b1;
                end else begin
                    hold_full_s = hold_full_r;
                end
                if (bit_end_s) begin
                    state_s = STOP_BIT;
                    out_s   = 1'b1;
                end else begin
                    out_s   = par_r;
                end
            end
`endif
            STOP_BIT: begin
                done_s = (cnt_r == CNT_PRE);
                if (bit_end_s) begin
                    if (hold_full_r) begin
                        shift_s     = hold_r;
`ifdef UART_TX_PARITY_EN
                        par_s       = even_parity(hold_r);
`endif
                        hold_full_s = 1'b0;
                        state_s     = START_BIT;
                        out_s       = 1'b0;
                    end else if (accept_s) begin
                        shift_s     = in_data;
`ifdef UART_TX_PARITY_EN
                        par_s       = even_parity(in_data);
`endif
                        state_s     = START_BIT;
                        out_s       = 1'b0;
                    end else begin
                        state_s     = IDLE;
                        out_s       = 1'b1;
                    end
                end else if (accept_s) begin
                    hold_s      = in_data;
                    hold_full_s = 1'b1;
                    out_s       = 1'b1;
                end else begin
                    out_s       = 1'b1;
                end
            end
            default: begin
                // Unreachable encodings recover to a clean idle line.
                state_s     = IDLE;
                cnt_s       = {CW{1'b0}};
                idx_s       = 3'd0;
                hold_full_s = 1'b0;
                out_s       = 1'b1;
            end
        endcase

        ready_s  = ~hold_full_s;
        active_s = (state_s != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            out_r       <= 1'b1;
            done_r      <= 1'b0;
            active_r    <= 1'b0;
            ready_r     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            shift_r     <= shift_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            out_r       <= out_s;
            done_r      <= done_s;
            active_r    <= active_s;
            ready_r     <= ready_s;
`ifdef UART_TX_PARITY_EN
            par_r       <= par_s;
`endif
        end
    end

    assign in_ready   = ready_r;
    assign out        = out_r;
    assign out_active = active_r;
    assign out_done   = done_r;

endmodule
